seg_scan_capture: RTL and testbench
===================================

Name: seg_scan_capture

Overview:
- Receive-side counterpart of the team's 8-digit multiplexed seven-segment driver.
- Samples the scanned active-low segment bus and active-low digit-select bus.
- Decodes each stable digit slot back to a hex nibble and reassembles the full 32-bit display value plus an 8-bit digit-enable mask.
- Used on the FPGA to read back an external display, and as a self-check monitor on the team's own display outputs.

Parameters:
SETTLE_CYCLES, 16, consecutive identical synchronized samples required before a slot is captured (2..255)
TIMEOUT_CYCLES, 100_000, idle cycles with a frame open before it is force-closed (2 ms at 50 MHz; exceeds the 1 ms digit period)

Ports:
sys_clk  input  1  system clock, 50 MHz
sys_rst  input  1  asynchronous, active-high reset
seg_val_in  input  8  segment pattern, active-low, common-anode encoding
seg_sel_in  input  8  digit select, active-low; bit i low = display position i
cap_val  output  32  captured value; position i occupies bits [4*(7-i)+3 : 4*(7-i)]
cap_en  output  8  captured enable mask; bit (7-i) set = position i was lit in the frame
cap_valid  output  1  frame available; held until accepted
cap_ready  input  1  consumer accepts when cap_valid && cap_ready
cap_err  output  1  an undecodable pattern or multi-hot select occurred in the published frame
cap_ovr  output  1  sticky: a frame was published while the previous one was unaccepted

Behaviour:
- Reset: all outputs 0; state IDLE; working registers cleared; synchronizer flops cleared to 8'hFF (inactive).
- Input path:
  - seg_val_in and seg_sel_in pass through a 2-flop synchronizer.
  - A stability counter counts consecutive cycles in which both synchronized buses equal their previous-cycle values. It saturates at SETTLE_CYCLES and clears to 0 on any change.
  - A capture event fires for exactly one cycle when the counter first reaches SETTLE_CYCLES; at most one event per stable episode.
- Capture-event classification:
  - sel == 8'hFF: blank slot; ignored; no event.
  - Exactly one zero at bit p: valid slot at position p.
  - More than one zero: error. Set the working error flag; no nibble is stored.
- Decode table:
  - C0→0, F9→1, A4→2, B0→3, 99→4, 92→5, 82→6, F8→7
  - 80→8, 90→9, 88→A, 83→B, A7→C, A1→D, 84→E, 8E→F
  - Any other pattern: nibble 0, position still marked enabled, working error flag set.
- State machine:
  - IDLE, valid slot: clear the working value/mask/error, store the slot, last_pos = p, go to COLLECT.
  - COLLECT, valid slot with p > last_pos: store the slot, last_pos = p.
  - COLLECT, valid slot with p <= last_pos (scan wrapped): publish the current frame; in the same cycle start a new frame holding this slot. Stay in COLLECT.
  - COLLECT, idle timer reaches TIMEOUT_CYCLES with no capture event: publish; go to IDLE.
  - The idle timer clears on every capture event, including blank-slot stabilization.
  - A duplicate p within a frame can only appear as a wrap and is handled by the wrap rule.
- Publish, one cycle:
  - Load cap_val/cap_en/cap_err from the working registers.
  - Set cap_valid = 1.
  - If cap_valid was already 1 and cap_ready is 0 that cycle: overwrite the outputs and set cap_ovr.
- Handshake:
  - cap_valid drops the cycle after cap_valid && cap_ready, unless a publish occurs in that same cycle; a publish has priority and keeps cap_valid = 1.
  - cap_ovr clears only on reset.
- Latency: 2 synchronizer cycles + SETTLE_CYCLES to a capture event; publish occurs 1 cycle after the wrap event.
- Reset mid-frame: the working frame is discarded and nothing is published.

Optional Feature:
SEG_SCAN_CAPTURE_DP_EN
- Defined:
  - Bit 7 of the pattern is treated as the decimal point and excluded from the lookup; decoding uses bits [6:0] with bit 7 forced to 1.
  - Adds output cap_dp [7:0]: bit (7-i) set when position i showed DP lit (bit 7 low). It is published and cleared alongside cap_en.
- Undefined:
  - No cap_dp port.
  - A pattern with bit 7 low fails the table and raises the error flag.

Test Plan:
- Scan all 8 positions ascending with value 32'h1234ABCD, sel all enabled, 1000-cycle slots, two full scans:
  - first publish after position 0 of scan 2: cap_val = 32'h1234ABCD, cap_en = 8'hFF, cap_err = 0.
- Same scan with positions 2 and 5 blank (sel = 8'hFF during those slots):
  - cap_en = 8'hDB; those nibbles read 0.
- Pattern 8'hFF on position 3:
  - cap_err = 1 for that frame; the next clean frame gives cap_err = 0.
- Glitch: sel held for only SETTLE_CYCLES-2 cycles before changing:
  - no capture for that slot; the position is absent from cap_en.
- Hold cap_ready = 0 across two published frames:
  - cap_ovr = 1; cap_val equals the second frame.
  - Assert cap_ready: cap_valid drops the next cycle.
- Stop the scan after position 4; assert sys_rst during a later frame:
  - the timeout publishes cap_en = 8'hF8 after TIMEOUT_CYCLES.
  - After reset, all outputs are 0 and no stale frame is published.

Source files
------------

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: reads back an 8-digit multiplexed seven-segment display and reassembles value/enable frames.
// Optional feature macro SEG_SCAN_CAPTURE_DP_EN adds decimal-point capture on cap_dp.
module seg_scan_capture #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  seg_val_in,
    input  logic [7:0]  seg_sel_in,
    output logic [31:0] cap_val,
    output logic [7:0]  cap_en,
`ifdef SEG_SCAN_CAPTURE_DP_EN
    output logic [7:0]  cap_dp,
`endif
    output logic        cap_valid,
    input  logic        cap_ready,
    output logic        cap_err,
    output logic        cap_ovr
);

    localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] SETTLE8  = 8'(SETTLE_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    // Returns {decodable, nibble}; common-anode, active-low segments.
    function automatic logic [4:0] seg_decode(input logic [7:0] pat);
        logic [4:0] r;
        case (pat)
            8'hC0:   r = {1'b1, 4'h0};
            8'hF9:   r = {1'b1, 4'h1};
            8'hA4:   r = {1'b1, 4'h2};
            8'hB0:   r = {1'b1, 4'h3};
            8'h99:   r = {1'b1, 4'h4};
            8'h92:   r = {1'b1, 4'h5};
            8'h82:   r = {1'b1, 4'h6};
            8'hF8:   r = {1'b1, 4'h7};
            8'h80:   r = {1'b1, 4'h8};
            8'h90:   r = {1'b1, 4'h9};
            8'h88:   r = {1'b1, 4'hA};
            8'h83:   r = {1'b1, 4'hB};
            8'hA7:   r = {1'b1, 4'hC};
            8'hA1:   r = {1'b1, 4'hD};
            8'h84:   r = {1'b1, 4'hE};
            8'h8E:   r = {1'b1, 4'hF};
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    logic [7:0] seg_s1_q, seg_s2_q, seg_s3_q;
    logic [7:0] sel_s1_q, sel_s2_q, sel_s3_q;
    logic [7:0] stab_q, stab_d;
    logic       evt_q, evt_d;
    logic [7:0] evt_seg_q, evt_sel_q;
    logic       same;

    // Synchronizer, one extra delay stage for change detection, and the settle counter.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            seg_s1_q  <= 8'hFF;
            seg_s2_q  <= 8'hFF;
            seg_s3_q  <= 8'hFF;
            sel_s1_q  <= 8'hFF;
            sel_s2_q  <= 8'hFF;
            sel_s3_q  <= 8'hFF;
            stab_q    <= 8'd0;
            evt_q     <= 1'b0;
            evt_seg_q <= 8'hFF;
            evt_sel_q <= 8'hFF;
        end else begin
            seg_s1_q <= seg_val_in;
            seg_s2_q <= seg_s1_q;
            seg_s3_q <= seg_s2_q;
            sel_s1_q <= seg_sel_in;
            sel_s2_q <= sel_s1_q;
            sel_s3_q <= sel_s2_q;
            stab_q   <= stab_d;
            evt_q    <= evt_d;
            if (evt_d) begin
                evt_seg_q <= seg_s2_q;
                evt_sel_q <= sel_s2_q;
            end
        end
    end

    always_comb begin
        same   = (seg_s2_q == seg_s3_q) && (sel_s2_q == sel_s3_q);
        stab_d = 8'd0;
        evt_d  = 1'b0;
        if (same) begin
            stab_d = (stab_q == SETTLE8) ? SETTLE8 : stab_q + 8'd1;
            // Only the transition into saturation fires, so one event per stable episode.
            evt_d  = (stab_q == SETTLE8 - 8'd1);
        end
    end

    logic [7:0] zeros;
    logic       multi, single;
    logic [2:0] pos;
    logic [4:0] dec;
    logic       slot_ok;
    logic [3:0] slot_nib;
    logic [4:0] nib_lo;
    logic [2:0] en_idx;

    always_comb begin
        zeros  = ~evt_sel_q;
        multi  = (zeros & (zeros - 8'd1)) != 8'd0;
        single = (zeros != 8'd0) && !multi;
        pos    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (zeros[i]) pos = 3'(i);
        end
`ifdef SEG_SCAN_CAPTURE_DP_EN
        dec = seg_decode(evt_seg_q | 8'h80);
`else
        dec = seg_decode(evt_seg_q);
`endif
        slot_ok  = dec[4];
        slot_nib = dec[3:0];
        en_idx   = 3'd7 - pos;
        nib_lo   = {en_idx, 2'b00};
    end

    state_t        state_q, state_d;
    logic [31:0]   wval_q, wval_d;
    logic [7:0]    wen_q, wen_d;
    logic          werr_q, werr_d;
    logic [2:0]    last_q, last_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          publish, start_new, store;
`ifdef SEG_SCAN_CAPTURE_DP_EN
    logic [7:0]    wdp_q, wdp_d;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            wval_q  <= 32'd0;
            wen_q   <= 8'd0;
            werr_q  <= 1'b0;
            last_q  <= 3'd0;
            timer_q <= '0;
`ifdef SEG_SCAN_CAPTURE_DP_EN
            wdp_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            wval_q  <= wval_d;
            wen_q   <= wen_d;
            werr_q  <= werr_d;
            last_q  <= last_d;
            timer_q <= timer_d;
`ifdef SEG_SCAN_CAPTURE_DP_EN
            wdp_q   <= wdp_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        wval_d    = wval_q;
        wen_d     = wen_q;
        werr_d    = werr_q;
        last_d    = last_q;
        timer_d   = timer_q;
        publish   = 1'b0;
        start_new = 1'b0;
        store     = 1'b0;
`ifdef SEG_SCAN_CAPTURE_DP_EN
        wdp_d     = wdp_q;
`endif
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (evt_q && single) begin
                    start_new = 1'b1;
                    store     = 1'b1;
                    state_d   = COLLECT;
                end
            end
            COLLECT: begin
                if (evt_q) begin
                    timer_d = '0;
                    if (single) begin
                        store = 1'b1;
                        // A position at or below the last one means the scan wrapped.
                        if (pos <= last_q) begin
                            publish   = 1'b1;
                            start_new = 1'b1;
                        end
                    end else if (multi) begin
                        werr_d = 1'b1;
                    end
                end else if (timer_q == TMO_LAST) begin
                    publish = 1'b1;
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_new) begin
            wval_d = 32'd0;
            wen_d  = 8'd0;
            werr_d = 1'b0;
`ifdef SEG_SCAN_CAPTURE_DP_EN
            wdp_d  = 8'd0;
`endif
        end
        if (store) begin
            wval_d[nib_lo +: 4] = slot_nib;
            wen_d[en_idx]       = 1'b1;
            last_d              = pos;
            if (!slot_ok) werr_d = 1'b1;
`ifdef SEG_SCAN_CAPTURE_DP_EN
            wdp_d[en_idx] = ~evt_seg_q[7];
`endif
        end
    end

    logic [31:0] cap_val_q;
    logic [7:0]  cap_en_q;
    logic        cap_valid_q, cap_err_q, cap_ovr_q;
`ifdef SEG_SCAN_CAPTURE_DP_EN
    logic [7:0]  cap_dp_q;
`endif

    // Publish wins over the handshake so a fresh frame is never dropped.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cap_val_q   <= 32'd0;
            cap_en_q    <= 8'd0;
            cap_valid_q <= 1'b0;
            cap_err_q   <= 1'b0;
            cap_ovr_q   <= 1'b0;
`ifdef SEG_SCAN_CAPTURE_DP_EN
            cap_dp_q    <= 8'd0;
`endif
        end else if (publish) begin
            cap_val_q   <= wval_q;
            cap_en_q    <= wen_q;
            cap_err_q   <= werr_q;
            cap_valid_q <= 1'b1;
            if (cap_valid_q && !cap_ready) cap_ovr_q <= 1'b1;
`ifdef SEG_SCAN_CAPTURE_DP_EN
            cap_dp_q    <= wdp_q;
`endif
        end else if (cap_valid_q && cap_ready) begin
            cap_valid_q <= 1'b0;
        end
    end

    assign cap_val   = cap_val_q;
    assign cap_en    = cap_en_q;
    assign cap_valid = cap_valid_q;
    assign cap_err   = cap_err_q;
    assign cap_ovr   = cap_ovr_q;
`ifdef SEG_SCAN_CAPTURE_DP_EN
    assign cap_dp    = cap_dp_q;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Randomized and directed scans of seg_scan_capture checked against a frame-level reference model.
module tb_seg_scan_capture;

    localparam int SETTLE = 6;
    localparam int TMO    = 300;
    localparam int SLOT   = 30;
    localparam int K_LIT = 0, K_BLANK = 1, K_GLITCH = 2, K_MULTI = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg, sel;
    logic [31:0] cap_val;
    logic [7:0]  cap_en;
    logic        cap_valid, cap_ready, cap_err, cap_ovr;

    always #5 clk = ~clk;

    seg_scan_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk(clk), .sys_rst(rst), .seg_val_in(seg), .seg_sel_in(sel),
        .cap_val(cap_val), .cap_en(cap_en), .cap_valid(cap_valid),
        .cap_ready(cap_ready), .cap_err(cap_err), .cap_ovr(cap_ovr)
    );

    typedef struct packed {
        logic [31:0] v;
        logic [7:0]  en;
        logic        err;
    } exp_t;

    exp_t       expq[$];
    exp_t       last_exp;
    int         n_cmp = 0, n_bad = 0;
    bit         mon_en = 1'b1;
    logic [7:0] seg_tab [16];
    int         fr_kind [8];
    logic [7:0] fr_pat  [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int ref_decode(input logic [7:0] p);
        int r = -1;
        for (int i = 0; i < 16; i++) if (seg_tab[i] == p) r = i;
        return r;
    endfunction

    task automatic drive(input logic [7:0] s_sel, input logic [7:0] s_seg, input int n);
        sel = s_sel;
        seg = s_seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic set_frame_val(input logic [31:0] v, input logic [7:0] en);
        for (int p = 0; p < 8; p++) begin
            fr_kind[p] = en[7-p] ? K_LIT : K_BLANK;
            fr_pat[p]  = seg_tab[v[4*(7-p) +: 4]];
        end
    endtask

    task automatic rand_frame();
        int r;
        fr_kind[0] = K_LIT;
        fr_pat[0]  = seg_tab[$urandom_range(0, 15)];
        for (int p = 1; p < 8; p++) begin
            r = $urandom_range(0, 9);
            fr_pat[p] = seg_tab[$urandom_range(0, 15)];
            if (r <= 5)      fr_kind[p] = K_LIT;
            else if (r == 6) fr_kind[p] = K_BLANK;
            else if (r == 7) fr_kind[p] = K_GLITCH;
            else if (r == 8) fr_kind[p] = K_MULTI;
            else begin
                fr_kind[p] = K_LIT;
                fr_pat[p]  = 8'($urandom_range(0, 255));
            end
        end
    endtask

    // Builds the expected frame from the slot list, then drives one full ascending scan.
    task automatic run_scan(input bit push);
        exp_t       e;
        logic [7:0] oh;
        int         d;
        e = '0;
        for (int p = 0; p < 8; p++) begin
            if (fr_kind[p] == K_LIT) begin
                d = ref_decode(fr_pat[p]);
                e.en[7-p] = 1'b1;
                if (d < 0) e.err = 1'b1;
                else e.v[4*(7-p) +: 4] = 4'(d);
            end else if (fr_kind[p] == K_MULTI) begin
                e.err = 1'b1;
            end
        end
        last_exp = e;
        if (push) expq.push_back(e);
        for (int p = 0; p < 8; p++) begin
            oh = 8'(1) << p;
            case (fr_kind[p])
                K_LIT:    drive(~oh, fr_pat[p], SLOT);
                K_GLITCH: begin
                    drive(~oh, fr_pat[p], SETTLE - 2);
                    drive(8'hFF, 8'hFF, SLOT - SETTLE + 2);
                end
                K_MULTI:  drive(~(oh | (8'(1) << ((p + 1) % 8))), fr_pat[p], SLOT);
                default:  drive(8'hFF, 8'hFF, SLOT);
            endcase
        end
    endtask

    task automatic wait_idle();
        seg = 8'hFF;
        sel = 8'hFF;
        repeat (TMO + 60) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst && cap_valid && cap_ready) begin
            if (expq.size() == 0) begin
                chk("unexpected_publish", 32'(cap_valid), 32'd0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("frame_val", cap_val, e.v);
                chk("frame_en", 32'(cap_en), 32'(e.en));
                chk("frame_err", 32'(cap_err), 32'(e.err));
            end
        end
    end

    initial begin
        exp_t b;
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h84, 8'h8E};
        rst = 1'b1;
        seg = 8'hFF;
        sel = 8'hFF;
        cap_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_val", cap_val, 32'd0);
        chk("rst_en", 32'(cap_en), 32'd0);
        chk("rst_valid", 32'(cap_valid), 32'd0);
        chk("rst_err", 32'(cap_err), 32'd0);
        chk("rst_ovr", 32'(cap_ovr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        set_frame_val(32'h1234ABCD, 8'hFF);
        run_scan(1'b1);
        run_scan(1'b1);
        set_frame_val(32'h1234ABCD, 8'hDB);
        run_scan(1'b1);
        set_frame_val(32'h1234ABCD, 8'hFF);
        fr_pat[3] = 8'hFF;
        run_scan(1'b1);
        set_frame_val(32'h56789EF0, 8'hFF);
        run_scan(1'b1);
        set_frame_val(32'h0F1E2D3C, 8'hFF);
        fr_kind[6] = K_GLITCH;
        run_scan(1'b1);
        repeat (10) begin
            rand_frame();
            run_scan(1'b1);
        end
        set_frame_val(32'hCAFE0000, 8'hF8);
        run_scan(1'b1);
        wait_idle();
        chk("queue_drained_1", 32'(expq.size()), 32'd0);
        chk("ovr_clear", 32'(cap_ovr), 32'd0);

        mon_en = 1'b0;
        cap_ready = 1'b0;
        set_frame_val(32'h11112222, 8'hFF);
        run_scan(1'b0);
        set_frame_val(32'h33334444, 8'hEF);
        run_scan(1'b0);
        b = last_exp;
        set_frame_val(32'h55556666, 8'hFF);
        run_scan(1'b1);
        chk("ovr_set", 32'(cap_ovr), 32'd1);
        chk("ovr_val", cap_val, b.v);
        chk("ovr_en", 32'(cap_en), 32'(b.en));
        chk("ovr_valid", 32'(cap_valid), 32'd1);
        cap_ready = 1'b1;
        @(negedge clk);
        chk("valid_drop", 32'(cap_valid), 32'd0);
        mon_en = 1'b1;
        wait_idle();
        chk("queue_drained_2", 32'(expq.size()), 32'd0);

        for (int p = 0; p < 4; p++) drive(~(8'(1) << p), seg_tab[p + 9], SLOT);
        rst = 1'b1;
        seg = 8'hFF;
        sel = 8'hFF;
        @(negedge clk);
        chk("rst2_val", cap_val, 32'd0);
        chk("rst2_en", 32'(cap_en), 32'd0);
        chk("rst2_valid", 32'(cap_valid), 32'd0);
        chk("rst2_err", 32'(cap_err), 32'd0);
        chk("rst2_ovr", 32'(cap_ovr), 32'd0);
        rst = 1'b0;
        repeat (TMO + 60) @(negedge clk);
        chk("no_stale_publish", 32'(cap_valid), 32'd0);
        chk("queue_drained_3", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
